// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the binary32 multiplier datapath.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } r_mode_e;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FIN = 31'h7F7F_FFFF;
  localparam int          BIAS    = 127;

  // Internal exponent width: wide enough that +1 normalization and rounding
  // carries never wrap a 10-bit signed input exponent.
  localparam int NE_W = 16;

  typedef struct packed {
    logic            sign;
    logic [NE_W-1:0] e;
    logic [22:0]     mant;
    logic            g;
    logic            s;
    r_mode_e         mode;
    logic            zero;
    logic            inf;
    logic            nan;
  } norm_t;

  // Encodings 5-7 are reserved and behave as round-to-nearest-even.
  function automatic r_mode_e decode_mode(input logic [2:0] m);
    if (m > 3'd4) return RNE;
    return r_mode_e'(m);
  endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment decision shared by the multiplier's rounding paths.
module fp_round_inc
  import fp_mul_pkg::*;
(
  input  r_mode_e mode,
  input  logic    sign,
  input  logic    lsb,
  input  logic    g,
  input  logic    s,
  output logic    inc
);

  always_comb begin
    inc = 1'b0;
    case (mode)
      RNE:     inc = g & (s | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (g | s);
      RUP:     inc = ~sign & (g | s);
      RMM:     inc = g;
      default: inc = g & (s | lsb);
    endcase
  end

endmodule

// File: rtl/fp_mul_round_pack.sv
// Normalize, round and pack the 48-bit significand product into binary32.
// Optional gradual underflow via FP_MUL_SUBNORMAL_EN (default: flush-to-zero).
module fp_mul_round_pack
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int PROD_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_zero,
  input  logic              in_inf,
  input  logic              in_nan,
  input  logic [2:0]        r_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       fp_Z,
  output logic              ovrf,
  output logic              udrf
);

  localparam logic signed [NE_W-1:0] E_ZERO = NE_W'(0);
  localparam logic signed [NE_W-1:0] E_OVF  = NE_W'(255);

  logic                   en;
  logic                   vld_p1;
  norm_t                  norm_d;
  norm_t                  norm_p1;
  logic signed [NE_W-1:0] exp_ext;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign exp_ext  = {{(NE_W-EXP_W){in_exp[EXP_W-1]}}, in_exp};

  // Overflow saturates to infinity unless the mode rounds toward zero for this sign.
  function automatic logic ovf_to_inf(input r_mode_e mode, input logic sign);
    case (mode)
      RTZ:     return 1'b0;
      RDN:     return sign;
      RUP:     return ~sign;
      default: return 1'b1;
    endcase
  endfunction

  // ---- stage 1: normalize product into [1,2) ----
  always_comb begin
    norm_d      = '0;
    norm_d.sign = in_sign;
    norm_d.mode = decode_mode(r_mode);
    norm_d.zero = in_zero;
    norm_d.inf  = in_inf;
    norm_d.nan  = in_nan;
    if (in_prod[PROD_W-1]) begin
      norm_d.mant = in_prod[46:24];
      norm_d.g    = in_prod[23];
      norm_d.s    = |in_prod[22:0];
      norm_d.e    = exp_ext + NE_W'(1);
    end else begin
      norm_d.mant = in_prod[45:23];
      norm_d.g    = in_prod[22];
      norm_d.s    = |in_prod[21:0];
      norm_d.e    = exp_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      norm_p1 <= norm_d;
    end
  end

  // ---- stage 2: round and pack ----
  logic signed [NE_W-1:0] e_p1;
  logic signed [NE_W-1:0] e_rnd;
  logic                   inc_n;
  logic                   c_n;
  logic [22:0]            m_n;

  assign e_p1 = $signed(norm_p1.e);

  fp_round_inc u_inc_norm (
    .mode (norm_p1.mode),
    .sign (norm_p1.sign),
    .lsb  (norm_p1.mant[0]),
    .g    (norm_p1.g),
    .s    (norm_p1.s),
    .inc  (inc_n)
  );

  assign {c_n, m_n} = {1'b0, norm_p1.mant} + 24'(inc_n);
  assign e_rnd      = e_p1 + NE_W'(c_n);

`ifdef FP_MUL_SUBNORMAL_EN
  localparam logic signed [NE_W-1:0] E_ONE    = NE_W'(1);
  localparam logic signed [NE_W-1:0] E_SH_MAX = NE_W'(25);

  logic signed [NE_W-1:0] sh_full;
  logic [4:0]             sh;
  logic [48:0]            wide;
  logic [22:0]            mant_s;
  logic [22:0]            m_s;
  logic                   g_s;
  logic                   s_s;
  logic                   inc_s;
  logic                   c_s;

  // Denormalize: the hidden bit moves into the fraction; everything
  // shifted past the guard position collapses into sticky.
  assign sh_full = E_ONE - e_p1;
  assign sh      = (sh_full > E_SH_MAX) ? 5'd25 : sh_full[4:0];
  assign wide    = 49'({1'b1, norm_p1.mant, norm_p1.g, 25'b0} >> sh);
  assign mant_s  = wide[48:26];
  assign g_s     = wide[25];
  assign s_s     = (|wide[24:0]) | norm_p1.s;

  fp_round_inc u_inc_sub (
    .mode (norm_p1.mode),
    .sign (norm_p1.sign),
    .lsb  (mant_s[0]),
    .g    (g_s),
    .s    (s_s),
    .inc  (inc_s)
  );

  assign {c_s, m_s} = {1'b0, mant_s} + 24'(inc_s);
`endif

  logic [31:0] res_z;
  logic        res_ov;
  logic        res_ud;

  always_comb begin
    res_z  = '0;
    res_ov = 1'b0;
    res_ud = 1'b0;
    if (norm_p1.nan) begin
      res_z = QNAN;
    end else if (norm_p1.inf) begin
      res_z = {norm_p1.sign, 8'hFF, 23'h0};
    end else if (norm_p1.zero) begin
      res_z = {norm_p1.sign, 31'h0};
    end else if (e_p1 <= E_ZERO) begin
`ifdef FP_MUL_SUBNORMAL_EN
      // A rounding carry into bit 23 lands naturally in exponent field 1.
      res_z  = {norm_p1.sign, 7'h0, c_s, m_s};
      res_ud = g_s | s_s;
`else
      res_z  = {norm_p1.sign, 31'h0};
      res_ud = 1'b1;
`endif
    end else if (e_rnd >= E_OVF) begin
      res_ov = 1'b1;
      res_z  = ovf_to_inf(norm_p1.mode, norm_p1.sign) ? {norm_p1.sign, 8'hFF, 23'h0}
                                                      : {norm_p1.sign, MAX_FIN};
    end else begin
      res_z = {norm_p1.sign, e_rnd[7:0], m_n};
    end
  end

  // ---- output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      fp_Z      <= '0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        fp_Z <= res_z;
        ovrf <= res_ov;
        udrf <= res_ud;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Randomized self-checking bench for fp_mul_round_pack against an arithmetic reference model.
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [2:0]  r_mode;
  logic        out_valid, out_ready, ovrf, udrf;
  logic [31:0] fp_Z;

  always #5 clk = ~clk;

  fp_mul_round_pack #(.EXP_W(10), .PROD_W(48)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod),
    .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan), .r_mode(r_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf)
  );

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] prod;
    logic        zero, inf, nan;
    logic [2:0]  mode;
  } vec_t;

  typedef struct {
    logic [33:0] res;   // {ovrf, udrf, fp_Z}
    int          cyc;
  } sb_t;

  sb_t  sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  logic lat_chk  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: treat the product as an integer, drop low bits, and round by
  // comparing the dropped remainder against half an ulp.
  function automatic logic [33:0] model(input vec_t v);
    int m, msb, e, drop;
    longint unsigned p, q, rem, half;
    logic inc;
    m = (v.mode > 3'd4) ? 0 : int'(v.mode);
    if (v.nan)  return {2'b00, 32'h7FC0_0000};
    if (v.inf)  return {2'b00, v.sign, 8'hFF, 23'h0};
    if (v.zero) return {2'b00, v.sign, 31'h0};
    msb  = v.prod[47] ? 47 : 46;
    e    = int'($signed(v.exp)) + msb - 46;
    drop = msb - 23;
    if (e <= 0) begin
`ifdef FP_MUL_SUBNORMAL_EN
      drop = drop + 1 - e;
      if (drop > 60) drop = 60;
`else
      return {2'b01, v.sign, 31'h0};
`endif
    end
    p    = 64'(v.prod);
    q    = p >> drop;
    rem  = p - (q << drop);
    half = 64'd1 << (drop - 1);
    case (m)
      0:       inc = (rem > half) || ((rem == half) && q[0]);
      1:       inc = 1'b0;
      2:       inc = v.sign && (rem != 0);
      3:       inc = !v.sign && (rem != 0);
      default: inc = (rem >= half);
    endcase
    q = q + 64'(inc);
    if (e <= 0) return {1'b0, rem != 0, v.sign, q[30:0]};
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      if (m == 0 || m == 4 || (m == 3 && !v.sign) || (m == 2 && v.sign))
        return {2'b10, v.sign, 8'hFF, 23'h0};
      return {2'b10, v.sign, 31'h7F7F_FFFF};
    end
    return {2'b00, v.sign, 8'(e), q[22:0]};
  endfunction

  function automatic vec_t mk(input logic s, input int e, input logic [47:0] p,
                              input logic [2:0] md, input logic [2:0] zin);
    vec_t v;
    v.sign = s; v.exp = 10'(e); v.prod = p; v.mode = md;
    {v.zero, v.inf, v.nan} = zin;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [23:0] mx, my;
    int k;
    v  = '0;
    mx = {1'b1, 23'($urandom)};
    my = {1'b1, 23'($urandom)};
    v.prod = 48'(mx) * 48'(my);
    if ($urandom_range(0, 5) == 0) v.prod[21:0] = '0;
    k = int'($urandom_range(0, 9));
    if (k == 0)      v.exp = 10'(-int'($urandom_range(0, 30)));
    else if (k == 1) v.exp = 10'($urandom_range(250, 300));
    else             v.exp = 10'($urandom_range(1, 254));
    v.sign = 1'($urandom);
    v.mode = 3'($urandom);
    k = int'($urandom_range(0, 15));
    if (k == 0) v.nan = 1'b1;
    if (k == 1) v.inf = 1'b1;
    if (k == 2) v.zero = 1'b1;
    if (k == 3) {v.zero, v.inf, v.nan} = 3'($urandom);
    return v;
  endfunction

  // One cycle: drive at negedge, then score the handshakes that the next posedge performs.
  task automatic step(input logic v, input vec_t d, input logic [33:0] ex,
                      input logic ordy, output logic acc);
    sb_t ent;
    @(negedge clk);
    cyc++;
    in_valid = v;  in_sign = d.sign; in_exp = d.exp; in_prod = d.prod;
    in_zero = d.zero; in_inf = d.inf; in_nan = d.nan; r_mode = d.mode;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        ent = sb.pop_front();
        check("fp_Z", 64'(fp_Z), 64'(ent.res[31:0]));
        check("ovrf", 64'(ovrf), 64'(ent.res[33]));
        check("udrf", 64'(udrf), 64'(ent.res[32]));
        if (lat_chk) check("latency", 64'(cyc - ent.cyc), 64'd2);
      end
    end
    acc = v && in_ready;
    if (acc) begin
      ent.res = ex;
      ent.cyc = cyc;
      sb.push_back(ent);
    end
  endtask

  task automatic dir(input logic s, input int e, input logic [47:0] p, input logic [2:0] md,
                     input logic [2:0] zin, input logic [33:0] ex);
    logic acc;
    step(1'b1, mk(s, e, p, md, zin), ex, 1'b1, acc);
    check("dir_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  localparam logic [47:0] P_ONE = 48'h4000_0000_0000;
  localparam logic [47:0] P_TIE = 48'h4000_0040_0000;

  initial begin
    vec_t v;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
    in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0; r_mode = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fp_Z", 64'(fp_Z), 64'd0);
    check("rst_ovrf", 64'(ovrf), 64'd0);
    check("rst_udrf", 64'(udrf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Directed vectors, back-to-back with no stall
    lat_chk = 1'b1;
    dir(0, 127, P_ONE, 3'd0, 3'b000, {2'b00, 32'h3F80_0000});
    dir(0, 127, 48'h9000_0000_0000, 3'd0, 3'b000, {2'b00, 32'h4010_0000});
    dir(0, 127, P_TIE, 3'd0, 3'b000, {2'b00, 32'h3F80_0000});
    dir(0, 127, P_TIE, 3'd1, 3'b000, {2'b00, 32'h3F80_0000});
    dir(0, 127, P_TIE, 3'd2, 3'b000, {2'b00, 32'h3F80_0000});
    dir(0, 127, P_TIE, 3'd3, 3'b000, {2'b00, 32'h3F80_0001});
    dir(0, 127, P_TIE, 3'd4, 3'b000, {2'b00, 32'h3F80_0001});
    dir(0, 127, P_TIE, 3'd6, 3'b000, {2'b00, 32'h3F80_0000});
    dir(1, 127, P_TIE, 3'd2, 3'b000, {2'b00, 32'hBF80_0001});
    dir(0, 127, 48'h7FFF_FFFF_FFFF, 3'd3, 3'b000, {2'b00, 32'h4000_0000});
    dir(0, 300, P_ONE, 3'd0, 3'b000, {2'b10, 32'h7F80_0000});
    dir(0, 300, P_ONE, 3'd1, 3'b000, {2'b10, 32'h7F7F_FFFF});
    dir(1, 300, P_ONE, 3'd2, 3'b000, {2'b10, 32'hFF80_0000});
    dir(1, 300, P_ONE, 3'd3, 3'b000, {2'b10, 32'hFF7F_FFFF});
`ifdef FP_MUL_SUBNORMAL_EN
    dir(0, -5, P_ONE, 3'd0, 3'b000, {2'b00, 32'h0002_0000});
`else
    dir(0, -5, P_ONE, 3'd0, 3'b000, {2'b01, 32'h0000_0000});
`endif
    dir(0, 127, P_ONE, 3'd0, 3'b001, {2'b00, 32'h7FC0_0000});
    dir(1, 127, P_ONE, 3'd0, 3'b010, {2'b00, 32'hFF80_0000});
    dir(1, 127, P_ONE, 3'd0, 3'b100, {2'b00, 32'h8000_0000});
    dir(1, 127, P_ONE, 3'd0, 3'b111, {2'b00, 32'h7FC0_0000});
    drain();
    lat_chk = 1'b0;

    // Backpressure: two results buffer, third input is refused until release
    step(1'b1, mk(0, 127, P_ONE, 3'd0, 3'b000), {2'b00, 32'h3F80_0000}, 1'b0, acc);
    check("bp_acc_a", 64'(acc), 64'd1);
    step(1'b1, mk(0, 127, 48'h9000_0000_0000, 3'd0, 3'b000), {2'b00, 32'h4010_0000}, 1'b0, acc);
    check("bp_acc_b", 64'(acc), 64'd1);
    v = mk(0, 127, 48'h7FFF_FFFF_FFFF, 3'd3, 3'b000);
    step(1'b1, v, {2'b00, 32'h4000_0000}, 1'b0, acc);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold", 64'(fp_Z), 64'h3F80_0000);
    step(1'b1, v, {2'b00, 32'h4000_0000}, 1'b0, acc);
    check("bp_refused", 64'(acc), 64'd0);
    check("bp_stable", 64'(fp_Z), 64'h3F80_0000);
    step(1'b1, v, {2'b00, 32'h4000_0000}, 1'b1, acc);
    check("bp_acc_c", 64'(acc), 64'd1);
    drain();

    // Randomized traffic with random stalls
    for (int i = 0; i < 600; i++) begin
      v = rand_vec();
      step($urandom_range(0, 3) != 0, v, model(v), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // Reset in the middle of a stream discards everything in flight
    for (int i = 0; i < 4; i++) begin
      v = rand_vec();
      step(1'b1, v, model(v), 1'b1, acc);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_fp_Z", 64'(fp_Z), 64'd0);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, acc);
    check("post_rst_idle", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
